// File: rtl/rr_arb_pkg.sv
// Shared types and round-robin pick helper for rr_data_arbiter.
// Provides state_t, default parameters and rr_pick().
package rr_arb_pkg;

    typedef enum logic {
        IDLE,
        GRANTED
    } state_t;

    localparam int DEF_N_REQ    = 4;
    localparam int DEF_DW       = 4;
    localparam int DEF_MAX_HOLD = 4;

    // rr_pick works on a fixed-width vector; unused upper bits are zero,
    // so wrapping modulo MAX_REQ gives the same order as modulo N_REQ.
    localparam int MAX_REQ = 32;
    localparam int IDX_W   = 5;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } pick_t;

    // Search starts at last+1; 'last' itself is visited last.
    // With exclude set, 'last' is not eligible at all.
    function automatic pick_t rr_pick(
        input logic [MAX_REQ-1:0] req,
        input logic [IDX_W-1:0]   last,
        input logic               exclude
    );
        pick_t            p;
        logic [IDX_W-1:0] k;
        p = '0;
        for (int i = 1; i <= MAX_REQ; i++) begin
            k = last + IDX_W'(i);
            if (!p.valid && req[k] && !(exclude && (k == last))) begin
                p.valid = 1'b1;
                p.idx   = k;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/rr_arb_pick_comb.sv
// Combinational rotate-and-priority-encode for the round-robin arbiter.
// Ports: req, last, exclude in; valid, idx out.
module rr_pick_comb
    import rr_arb_pkg::*;
#(
    parameter  int N_REQ = DEF_N_REQ,
    localparam int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    last,
    input  logic             exclude,
    output logic             valid,
    output logic [IW-1:0]    idx
);

    pick_t p;

    always_comb begin
        p     = rr_pick(MAX_REQ'(req), IDX_W'(last), exclude);
        valid = p.valid;
        idx   = IW'(p.idx);
    end

endmodule

// File: rtl/rr_data_arbiter.sv
// Round-robin arbiter sharing one registered data bus among N_REQ requesters.
// Ports: clk, rst_n, req, req_data, [lock], grant, out_data, out_valid,
// out_en, busy. Optional macro ARB_LOCK_EN adds 'lock' to extend tenure.
module rr_data_arbiter
    import rr_arb_pkg::*;
#(
    parameter int N_REQ    = DEF_N_REQ,
    parameter int DW       = DEF_DW,
    parameter int MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_REQ-1:0]  req,
    input  logic [N_REQ*DW-1:0] req_data,
`ifdef ARB_LOCK_EN
    input  logic              lock,
`endif
    output logic [N_REQ-1:0]  grant,
    output logic [DW-1:0]     out_data,
    output logic              out_valid,
    output logic              out_en,
    output logic              busy
);

    localparam int IW = $clog2(N_REQ);
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] MAX_H = HW'(MAX_HOLD);

    state_t         state;
    logic [HW-1:0]  hold_cnt;
    logic [IW-1:0]  last;
    logic           pick_valid;
    logic [IW-1:0]  pick_idx;
    logic           own_req;
    logic           hold_ok;
    logic           keep_own;

    // While granted, 'last' is the current owner.
    assign own_req = req[last];

`ifdef ARB_LOCK_EN
    assign hold_ok = (hold_cnt != MAX_H) || lock;
`else
    assign hold_ok = (hold_cnt != MAX_H);
`endif

    assign keep_own = own_req && hold_ok;

    rr_pick_comb #(
        .N_REQ(N_REQ)
    ) u_pick (
        .req    (req),
        .last   (last),
        .exclude(!own_req),
        .valid  (pick_valid),
        .idx    (pick_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            grant     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            hold_cnt  <= '0;
            last      <= IW'(N_REQ - 1);
        end else begin
            if ((state == GRANTED) && keep_own) begin
                out_data <= req_data[last*DW +: DW];
                if (hold_cnt != MAX_H) begin
                    hold_cnt <= hold_cnt + 1'b1;
                end
            end else if (pick_valid) begin
                // New grant from IDLE, or zero-gap handover on release.
                state     <= GRANTED;
                grant     <= N_REQ'(1) << pick_idx;
                out_data  <= req_data[pick_idx*DW +: DW];
                out_valid <= 1'b1;
                hold_cnt  <= HW'(1);
                last      <= pick_idx;
            end else begin
                state     <= IDLE;
                grant     <= '0;
                out_valid <= 1'b0;
                hold_cnt  <= '0;
            end
        end
    end

    assign busy   = (state == GRANTED);
    assign out_en = out_data[DW-1];

endmodule

// File: tb/tb_rr_data_arbiter.sv
// Scoreboard testbench for rr_data_arbiter (N_REQ=4, DW=4, MAX_HOLD=4).
// Define ARB_LOCK_EN to also exercise the lock feature.
module tb_rr_data_arbiter;

    typedef struct packed {
        logic [3:0] g;
        logic [3:0] d;
        logic       v;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = '0;
    logic [15:0] req_data = '0;
`ifdef ARB_LOCK_EN
    logic        lock = 1'b0;
`endif
    logic [3:0]  grant;
    logic [3:0]  out_data;
    logic        out_valid;
    logic        out_en;
    logic        busy;

    int   errors = 0;
    int   checks = 0;
    exp_t q[$];

    localparam logic [15:0] D = 16'h3C69;

    rr_data_arbiter #(
        .N_REQ(4),
        .DW(4),
        .MAX_HOLD(4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .req_data (req_data),
`ifdef ARB_LOCK_EN
        .lock     (lock),
`endif
        .grant    (grant),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_en   (out_en),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compare one queued expectation after each clock edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rst_n && q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if (grant !== e.g || out_data !== e.d || out_valid !== e.v ||
                out_en !== e.d[3] || busy !== e.v) begin
                errors++;
                $display("FAIL cycle t=%0t: got g=%b d=%h v=%b en=%b busy=%b expected g=%b d=%h v=%b en=%b busy=%b",
                         $time, grant, out_data, out_valid, out_en, busy,
                         e.g, e.d, e.v, e.d[3], e.v);
            end
        end
    end

    task automatic step(input logic [3:0] r, input logic [15:0] d,
                        input logic [3:0] eg, input logic [3:0] ed,
                        input logic ev);
        @(negedge clk);
        req      = r;
        req_data = d;
        q.push_back('{eg, ed, ev});
    endtask

    task automatic check_zero(input string name);
        chk({name, "_grant"}, {4'h0, grant}, 8'h00);
        chk({name, "_valid"}, {7'h0, out_valid}, 8'h00);
        chk({name, "_data"}, {4'h0, out_data}, 8'h00);
        chk({name, "_en"}, {7'h0, out_en}, 8'h00);
        chk({name, "_busy"}, {7'h0, busy}, 8'h00);
    endtask

    task automatic pulse_reset(input string name);
        @(negedge clk);
        req   = '0;
        rst_n = 1'b0;
        #1;
        check_zero(name);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #3;
        check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Single requester, then drop.
        step(4'b0001, D, 4'b0001, 4'h9, 1'b1);
        step(4'b0000, D, 4'b0000, 4'h9, 1'b0);

        pulse_reset("reset2");

        // Hold expiry with a competitor.
        for (int i = 0; i < 4; i++) step(4'b0011, D, 4'b0001, 4'h9, 1'b1);
        for (int i = 0; i < 4; i++) step(4'b0011, D, 4'b0010, 4'h6, 1'b1);
        step(4'b0011, D, 4'b0001, 4'h9, 1'b1);

        // Mid-tenure asynchronous reset.
        pulse_reset("reset_mid");

        // Fairness with all four requesting.
        for (int i = 0; i < 4; i++) step(4'b1111, D, 4'b0001, 4'h9, 1'b1);
        for (int i = 0; i < 4; i++) step(4'b1111, D, 4'b0010, 4'h6, 1'b1);
        for (int i = 0; i < 4; i++) step(4'b1111, D, 4'b0100, 4'hC, 1'b1);
        for (int i = 0; i < 4; i++) step(4'b1111, D, 4'b1000, 4'h3, 1'b1);
        step(4'b1111, D, 4'b0001, 4'h9, 1'b1);
        step(4'b0000, D, 4'b0000, 4'h9, 1'b0);

        // Early drop by requester 2; data lag and ignored foreign data.
        step(4'b0100, D, 4'b0100, 4'hC, 1'b1);
        step(4'b0100, 16'h3561, 4'b0100, 4'h5, 1'b1);
        step(4'b0000, D, 4'b0000, 4'h5, 1'b0);
        step(4'b0100, D, 4'b0100, 4'hC, 1'b1);
        step(4'b0000, D, 4'b0000, 4'hC, 1'b0);

`ifdef ARB_LOCK_EN
        pulse_reset("reset_lock");
        lock = 1'b1;
        for (int i = 0; i < 6; i++) step(4'b0011, D, 4'b0001, 4'h9, 1'b1);
        lock = 1'b0;
        step(4'b0011, D, 4'b0010, 4'h6, 1'b1);
        step(4'b0000, D, 4'b0000, 4'h6, 1'b0);
`endif

        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", 8'(q.size()), 8'h00);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/rr_data_arbiter.md
# rr_data_arbiter

Round-robin arbiter and sequencer that shares one 4-bit `logic` data register among several requesters. It grants one requester at a time, bounds each tenure to a fixed number of cycles, and registers the granted requester's data onto a shared output bus. It also exports an enable tap taken from the output MSB. The block sits between multiple data producers and the single shared data/enable datapath consumed downstream.

## Interface
- `N_REQ`, default 4: number of requesters, ≥2.
- `DW`, default 4: data width, ≥1.
- `MAX_HOLD`, default 4: maximum consecutive grant cycles per tenure, ≥1.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `req` in N_REQ: per-requester request, level-sensitive.
- `req_data` in N_REQ*DW: packed data; requester i occupies bits [i*DW +: DW].
- `grant` out N_REQ: one-hot or zero registered grant.
- `out_data` out DW: registered shared data.
- `out_valid` out 1: high while `out_data` carries granted data.
- `out_en` out 1: equals `out_data[DW-1]`, continuous.
- `busy` out 1: high when the FSM is in GRANTED.

## Operation
- FSM states, held in `state_t`:
  - IDLE: waits for any request.
  - GRANTED: one requester owns the bus.
- Priority pointer `last` holds the index of the most recent winner. Search starts at `last+1` and wraps modulo N_REQ.
- IDLE, at an edge where `|req` is true:
  - The winner is registered in `grant`.
  - `out_data` loads `req_data[winner]`.
  - `out_valid` goes to 1.
  - `hold_cnt` goes to 1.
  - `last` goes to the winner.
  - The FSM enters GRANTED.
- GRANTED, each edge, for owner g:
  - Continue: if `req[g]` is high and `hold_cnt` < MAX_HOLD, then `out_data` reloads `req_data[g]` and `hold_cnt` increments.
  - Release: if `req[g]` is low, or `hold_cnt` == MAX_HOLD.
- On release, the next winner is chosen in the same edge, giving a zero-gap handover. The dropped or expired owner is searched last:
  - If another requester is pending, `grant` moves to it, `out_data` loads its data, and `hold_cnt` goes to 1.
  - If there is none but the expired owner still requests, it is re-granted and `hold_cnt` goes to 1.
  - If no request is pending, the FSM goes to IDLE, `grant` goes to 0, `out_valid` goes to 0, and `out_data` holds its last value.
- `hold_cnt` width is $clog2(MAX_HOLD+1). It never exceeds MAX_HOLD.
- `req_data` for non-granted requesters is ignored.

## Timing
- Reset values:
  - `grant` = 0
  - `out_data` = 0
  - `out_valid` = 0
  - `out_en` = 0
  - `busy` = 0
  - state = IDLE
  - `hold_cnt` = 0
  - `last` = N_REQ-1, so requester 0 wins first.
- Latency: a request asserted before edge k is granted at edge k, so `grant` and `out_data` are visible in cycle k+1.
- Tenure is at most MAX_HOLD cycles of `grant` high per owner before arbitration.
- `out_data` lags `req_data[g]` by one cycle while granted.
- Simultaneous requests are resolved by the round-robin order only. No requester waits more than (N_REQ-1)*MAX_HOLD cycles.
- Reset asserted mid-tenure clears all state immediately. The first grant after reset follows the reset pointer.

## Configuration
- `ARB_LOCK_EN` defined:
  - Adds input port `lock` (1 bit).
  - While the owner's `req` and `lock` are both high, the hold-expiry release is suppressed.
  - `hold_cnt` saturates at MAX_HOLD.
  - Release happens only when `req[g]` drops, or on the first edge after `lock` drops while `hold_cnt` == MAX_HOLD.
- `ARB_LOCK_EN` undefined: no `lock` port; the behaviour above applies unchanged.

## Structure
- Package `rr_arb_pkg`:
  - `state_t` enum {IDLE, GRANTED}.
  - Default parameter constants.
  - Function `rr_pick(req, last, exclude)` returning a valid flag and an index.
- One sub-module, `rr_pick_comb`: combinational rotate-and-priority-encode. Instantiated once in the top.
- The top holds the FSM, `hold_cnt`, `last` and the output registers.

## Test plan
All tests use N_REQ=4, DW=4, MAX_HOLD=4.

1. **Reset:** check outputs during `rst_n`=0 → all outputs 0. Assert `rst_n`=0 mid-tenure → `grant` and `out_valid` drop without waiting for a clock edge.
2. **Single requester:** `req`=4'b0001, `req_data[0]`=4'h9 → next cycle `grant`=0001, `out_data`=4'h9, `out_en`=1, `busy`=1.
3. **Hold expiry with a competitor:** `req`=4'b0011 held, with `req_data[0]`=4'h9 and `req_data[1]`=4'h6 → `grant`=0001 for exactly 4 cycles, then 0010 with no gap, then `out_data`=4'h6 and `out_en`=0.
4. **Fairness:** all four requesters held → grant order 0,1,2,3,0, with 4 cycles each.
5. **Early drop:** requester 2 drops `req` after 2 cycles with no other requester pending → next edge `grant`=0, `out_valid`=0, `out_data` holds 4'h?; a re-request is granted 1 cycle later.
6. **Lock (`ARB_LOCK_EN`):** `lock`=1 with `req`=4'b0011 → requester 0 keeps `grant` beyond 4 cycles; after `lock`=0, the handover to requester 1 occurs at the next edge.
